// File: rtl/dmem_bus_pkg.sv
// rtl/dmem_bus_pkg.sv - shared data-memory bus types and constants
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [31:0] SWITCH_ADDR = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR    = 32'hC000_0004;
  localparam int          WORD_BYTES  = 4;

endpackage

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - word copy engine acting as a second data-memory bus initiator
module dmem_copy_engine
  import dmem_bus_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  count;
  logic [31:0]       data_q;

  // Control FSM: one granted cycle per bus access, a lost grant simply holds the current state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      bus_req <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr & ALIGN_MASK;
            dst_ptr <= dst_addr & ALIGN_MASK;
            count   <= len;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RD;
              busy    <= 1'b1;
              bus_req <= 1'b1;
            end
          end
        end
        RD: begin
          if (bus_gnt) begin
            data_q <= mem_rd;
            state  <= WR;
          end
        end
        WR: begin
          if (bus_gnt) begin
            src_ptr <= src_ptr + STEP;
            dst_ptr <= dst_ptr + STEP;
            count   <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state   <= DONE;
              busy    <= 1'b0;
              bus_req <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus drive is gated by grant in the same cycle so an ungranted engine presents an all-zero bus
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (bus_gnt) begin
      case (state)
        RD: mem_a = src_ptr;
        WR: begin
          mem_a  = dst_ptr;
          mem_we = 1'b1;
          mem_wd = data_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - randomized self-checking bench for dmem_copy_engine
module tb_dmem_copy_engine;
  import dmem_bus_pkg::*;

  localparam int GP = 400;

  logic        clk = 1'b0;
  logic        reset, start, bus_gnt, bus_req, mem_we, busy, done;
  logic [31:0] src_addr, dst_addr, mem_a, mem_wd, mem_rd;
  logic [7:0]  len;

  always #5 clk = ~clk;

  dmem_copy_engine #(.LEN_W(8), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_a(mem_a), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .done(done)
  );

  // Bus environment: 256-word RAM, whole 0xC... region reads switches and writes LEDs
  logic [31:0] ram [256];
  logic [31:0] sw_val, led;

  always_comb begin
    if (mem_a[31:30] == 2'b11)   mem_rd = sw_val;
    else if (mem_a < 32'h400)    mem_rd = ram[mem_a[9:2]];
    else                         mem_rd = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a[31:30] == 2'b11) led = mem_wd;
      else if (mem_a < 32'h400)  ram[mem_a[9:2]] = mem_wd;
    end
  end

  // Reference model state
  logic [31:0] model_ram [256];
  logic [31:0] model_led;
  logic [31:0] exp_ra [64];
  logic [31:0] exp_wa [64];
  logic [31:0] exp_wd [64];
  int          gpat [GP];
  int          cyc, exp_done, busy_end, gidx, last_d;
  bit          cmp_en;
  int          n_pass, n_total;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a[31:30] == 2'b11) return sw_val;
    if (a < 32'h400)       return model_ram[a[9:2]];
    return 32'h0;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [31:0] v);
    if (a[31:30] == 2'b11)  model_led = v;
    else if (a < 32'h400)   model_ram[a[9:2]] = v;
  endtask

  // Per-cycle compare: granted cycles while busy alternate read, write, read, write...
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (cyc >= 1 && cyc < busy_end)});
      chk("bus_req", {31'b0, bus_req}, {31'b0, (cyc >= 1 && cyc < busy_end)});
      chk("done", {31'b0, done}, {31'b0, (exp_done != 0 && cyc == exp_done)});
      if (mem_we && !bus_gnt) chk("we_without_gnt", 32'd1, 32'd0);
      if (cyc >= 1 && cyc < busy_end && bus_gnt) begin
        if (gidx % 2 == 0) begin
          chk("rd_we", {31'b0, mem_we}, 32'd0);
          chk("rd_addr", mem_a, exp_ra[gidx/2]);
        end else begin
          chk("wr_we", {31'b0, mem_we}, 32'd1);
          chk("wr_addr", mem_a, exp_wa[gidx/2]);
          chk("wr_data", mem_wd, exp_wd[gidx/2]);
        end
        gidx++;
      end else begin
        chk("idle_a", mem_a, 32'd0);
        chk("idle_we", {31'b0, mem_we}, 32'd0);
        chk("idle_wd", mem_wd, 32'd0);
      end
    end
  end

  // mode 0: grant held, 1: pattern 1,0,0 repeating, 2: random; abort_w>=0 resets after that many writes
  task automatic run_copy(input logic [31:0] s, input logic [31:0] t, input int n,
                          input int mode, input int abort_w);
    int cnt, d, a, nw, lim;
    logic [31:0] ra, wa, v;
    for (int k = 0; k < GP; k++)
      gpat[k] = (mode == 0) ? 1 : (mode == 1) ? int'((k - 1) % 3 == 0) : int'($urandom % 4 != 0);
    nw = (abort_w >= 0) ? abort_w : n;
    for (int i = 0; i < n; i++) begin
      ra = (s & 32'hFFFF_FFFC) + 32'(4 * i);
      wa = (t & 32'hFFFF_FFFC) + 32'(4 * i);
      v  = mread(ra);
      exp_ra[i] = ra;
      exp_wa[i] = wa;
      exp_wd[i] = v;
      if (i < nw) mwrite(wa, v);
    end
    d = 1; a = 0; cnt = 0;
    if (n > 0) begin
      d = 0;
      for (int k = 1; k < GP; k++) begin
        if (gpat[k] != 0) begin
          cnt++;
          if (abort_w >= 0 && cnt == 2 * abort_w) a = k;
          if (cnt == 2 * n) begin
            d = k + 1;
            break;
          end
        end
      end
    end
    last_d = d;
    if (d == 0) begin
      chk("grant_pattern_long_enough", 32'd0, 32'd1);
      return;
    end
    gidx     = 0;
    exp_done = (abort_w >= 0) ? 0 : d;
    busy_end = (abort_w >= 0) ? a + 2 : ((n > 0) ? d : 1);
    start = 1'b1; src_addr = s; dst_addr = t; len = 8'(n); bus_gnt = 1'b1; cyc = 0;
    @(posedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len = 8'($urandom);
    lim = (abort_w >= 0) ? a + 4 : d + 2;
    for (int k = 1; k <= lim; k++) begin
      cyc     = k;
      bus_gnt = gpat[k][0];
      start   = (k < busy_end) && ($urandom % 4 == 0);
      reset   = !(abort_w >= 0 && k == a + 1);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b1; cyc = 0; exp_done = 0; busy_end = 0; bus_gnt = 1'b1;
    chk("grant_count", 32'(gidx), (abort_w >= 0) ? 32'(2 * abort_w + gpat[a + 1]) : 32'(2 * n));
    cnt = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_ram[i]) cnt++;
    chk("ram_words_wrong", 32'(cnt), 32'd0);
    chk("led", led, model_led);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cmp_en = 1'b0; cyc = 0; exp_done = 0; busy_end = 0; gidx = 0;
    reset = 1'b0; start = 1'b0; bus_gnt = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    sw_val = 32'h0000_02A5; led = '0; model_led = '0; last_d = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      model_ram[i] = ram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    reset = 1'b1; bus_gnt = 1'b1; cmp_en = 1'b1;
    @(posedge clk); #1;

    run_copy(32'h0, 32'h40, 4, 0, -1);
    chk("len4_done_cycle", 32'(last_d), 32'd9);
    chk("len4_last_word", ram[19], ram[3]);

    run_copy(32'h10, 32'h20, 0, 0, -1);
    chk("len0_done_cycle", 32'(last_d), 32'd1);

    run_copy(32'h100, 32'h140, 3, 1, -1);
    chk("len3_toggle_done_cycle", 32'(last_d), 32'd17);

    run_copy(SWITCH_ADDR, 32'h80, 2, 0, -1);
    chk("switch_word0", ram[32], 32'h0000_02A5);
    chk("switch_word1", ram[33], 32'h0000_02A5);

    run_copy(32'h180, LED_ADDR, 3, 2, -1);
    chk("led_last_word", led, ram[98]);

    run_copy(32'h200, 32'h300, 8, 0, 3);
    chk("abort_word3_untouched", ram[195], model_ram[195]);

    run_copy(32'h13, 32'h22, 1, 0, -1);
    chk("unaligned_copy", ram[8], ram[4]);

    run_copy(32'hFFFF_FFFC, 32'h3C0, 3, 1, -1);
    chk("wrap_first_word", ram[240], 32'h0000_02A5);

    for (int r = 0; r < 6; r++) begin
      int n, sw, dw;
      n  = $urandom_range(20, 0);
      sw = $urandom_range(255 - n, 0);
      dw = $urandom_range(255 - n, 0);
      run_copy(32'(sw * 4) | 32'($urandom_range(3, 0)), 32'(dw * 4) | 32'($urandom_range(3, 0)),
               n, $urandom_range(2, 0), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Memory-to-memory word copy engine that acts as a second initiator on the data-memory bus, the same single-port bus the processor core uses. It has combinational read data and a synchronous write. Software-side control (start, source, destination, length) comes in as registered inputs. Bus access is requested and granted by an external arbiter, so the engine copies blocks through RAM and memory-mapped peripheral addresses without processor involvement.

## Interface
- LEN_W, 8, width of word-count input (max copy = 2^LEN_W − 1 words)
- ADDR_W, 32, bus address width

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of 32-bit words to copy
- bus_req  out  1  engine requests the data bus
- bus_gnt  in  1  arbiter grant; engine drives bus only when high
- mem_a  out  ADDR_W  bus address
- mem_we  out  1  bus write enable
- mem_wd  out  32  bus write data
- mem_rd  in  32  bus read data (combinational from mem_a)
- busy  out  1  high from accepted start until the done pulse
- done  out  1  one-cycle pulse when the copy completes

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: on start=1, latch src/dst (with [1:0]=0) and len. If len=0, go to DONE. Otherwise go to RD and assert busy and bus_req. start while not in IDLE is ignored.
- RD: when bus_gnt=1, drive mem_a=src_ptr and mem_we=0, capture mem_rd into the data register at the clock edge, then go to WR. When bus_gnt=0, hold in RD and drive nothing.
- WR: when bus_gnt=1, drive mem_a=dst_ptr, mem_we=1 and mem_wd=data register. At the edge, src_ptr+=4, dst_ptr+=4 and count−=1. If count reaches 0, go to DONE; otherwise go to RD. When bus_gnt=0, hold in WR with the data register unchanged.
- DONE: pulse done for one cycle, deassert busy and bus_req, return to IDLE.
- Pointer arithmetic is modulo 2^ADDR_W; wrap past 0xFFFF_FFFC continues at 0.
- Peripheral addresses get no special treatment. A source of 0xC000_0000 rereads the switches on every word; a destination of 0xC000_0004 rewrites the LEDs on every word.
- Overlapping regions copy strictly ascending, word by word. No overlap correction.
- When not granted, or when in IDLE/DONE: mem_a=0, mem_we=0, mem_wd=0.

## Timing
- Reset (reset=0 at an edge) values: state IDLE; busy=0, done=0, bus_req=0, mem_we=0, mem_a=0, mem_wd=0; counters and pointers 0.
- Reset takes priority over all inputs, including in the middle of a copy. Words already written stay written; no done pulse.
- With continuous grant, N words take 2N cycles from the first RD cycle. done asserts in cycle 2N+1 after the start edge.
- len=0: done pulses in the cycle after start; no bus cycles occur.
- bus_req rises in the cycle after start is accepted and falls in the DONE cycle.
- Grant loss stalls exactly one state. There is no partial write, and mem_we is never high without bus_gnt.

## Structure
- Shared package `dmem_bus_pkg`:
  - state enum (IDLE, RD, WR, DONE);
  - constants SWITCH_ADDR=32'hC000_0000, LED_ADDR=32'hC000_0004, WORD_BYTES=4.
- One module; no sub-module required. The external arbiter/mux between core and engine lives outside this block.

## Test plan
- Copy RAM 0x00..0x0C to 0x40..0x4C (len=4), grant held high.
  - Four writes, destination words equal source words.
  - done in cycle 9 after start.
- len=0, src=0x10, dst=0x20.
  - done in the next cycle, mem_we never asserted, RAM unchanged.
- len=3 with bus_gnt toggling 1,0,0,1,… throughout.
  - Correct data copied, no write while bus_gnt=0.
  - Total cycles = 6 + number of stalled cycles.
- src=0xC000_0000 with switches=10'h2A5, dst=0x80, len=2.
  - Words 0x80 and 0x84 both read 0x0000_02A5.
- Start a len=8 copy, assert reset=0 after the third write.
  - All outputs return to 0 on the next edge and busy=0.
  - Only the first three destination words are modified.
- Unaligned src=0x13, dst=0x22, len=1.
  - Word at 0x10 copied to 0x20.
  - start pulses while busy are ignored (no restart, count unaffected).
